// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encodings, FSM states and the
// default data-memory depth.
package lsu_pkg;

  localparam int unsigned DEPTH_WORDS_DEFAULT = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    StIdle,
    StFault,
    StRead,
    StExtract,
    StMerge,
    StWrite,
    StDone
  } state_e;

endpackage

// File: rtl/lsu_if.sv
// Request/response bundle between the execute stage (master) and the load/store unit (slave).
interface lsu_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        misaligned;
  logic        out_of_range;

  modport master (
    output req, we, size, sign_ext, addr, wdata,
    input  rdata, busy, done, misaligned, out_of_range
  );

  modport slave (
    input  req, we, size, sign_ext, addr, wdata,
    output rdata, busy, done, misaligned, out_of_range
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extracts/extends a sub-word load from a memory word and
// merges a sub-word store into it.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        sign_ext,
  output logic [31:0] load_val,
  output logic [31:0] merge_val
);
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [4:0]  shamt;

  always_comb begin
    shamt     = {offset, 3'b000};
    byte_lane = 8'(word >> shamt);
    half_lane = offset[1] ? word[31:16] : word[15:0];
    load_val  = word;
    merge_val = word;
    unique case (size)
      SZ_BYTE: begin
        load_val  = {{24{sign_ext & byte_lane[7]}}, byte_lane};
        merge_val = (word & ~(32'h0000_00ff << shamt)) | ({24'b0, wdata[7:0]} << shamt);
      end
      SZ_HALF: begin
        load_val  = {{16{sign_ext & half_lane[15]}}, half_lane};
        merge_val = offset[1] ? {wdata, word[15:0]} : {word[31:16], wdata};
      end
      default: begin
        load_val  = word;
        merge_val = word;
      end
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage in front of the word-addressed data memory: checks and latches one
// request, then sequences read / read-modify-write / write while holding busy.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
  parameter int unsigned IDX_W       = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  lsu_if.slave        bus,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_writeIn,
  input  logic [31:0] mem_readOut,
  output logic        mem_writePin,
  output logic        mem_readPin
);
  state_e      state_q;
  logic        we_q;
  logic        sign_ext_q;
  size_e       size_q;
  logic [1:0]  offset_q;
  logic [15:0] wdata_q;
  logic [31:0] rdata_q;
  logic        done_q;
  logic        misaligned_q;
  logic        out_of_range_q;

  logic [29:0] word_idx;
  logic        req_misaligned;
  logic        req_out_of_range;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  assign word_idx = bus.addr[31:2];

  // Any index bit above the decoded width is out of range on its own.
  always_comb begin
    req_out_of_range = ((word_idx >> IDX_W) != '0)
                    || (32'(word_idx[IDX_W-1:0]) >= DEPTH_WORDS)
                    || (size_e'(bus.size) == SZ_ILL);
    unique case (size_e'(bus.size))
      SZ_HALF: req_misaligned = bus.addr[0];
      SZ_WORD: req_misaligned = (bus.addr[1:0] != 2'b00);
      default: req_misaligned = 1'b0;
    endcase
  end

  lsu_lane_align u_align (
    .word      (mem_readOut),
    .wdata     (wdata_q),
    .offset    (offset_q),
    .size      (size_q),
    .sign_ext  (sign_ext_q),
    .load_val  (load_val),
    .merge_val (merge_val)
  );

  // Memory pins are registered, so the async reset drops a pending write before its edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      we_q           <= 1'b0;
      sign_ext_q     <= 1'b0;
      size_q         <= SZ_BYTE;
      offset_q       <= 2'b00;
      wdata_q        <= '0;
      rdata_q        <= '0;
      done_q         <= 1'b0;
      misaligned_q   <= 1'b0;
      out_of_range_q <= 1'b0;
      mem_adr        <= '0;
      mem_writeIn    <= '0;
      mem_writePin   <= 1'b0;
      mem_readPin    <= 1'b0;
    end else begin
      done_q         <= 1'b0;
      misaligned_q   <= 1'b0;
      out_of_range_q <= 1'b0;
      mem_writePin   <= 1'b0;
      mem_readPin    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req) begin
            we_q       <= bus.we;
            sign_ext_q <= bus.sign_ext;
            size_q     <= size_e'(bus.size);
            offset_q   <= bus.addr[1:0];
            wdata_q    <= bus.wdata[15:0];
            mem_adr    <= {2'b00, word_idx};
            if (req_misaligned || req_out_of_range) begin
              state_q        <= StFault;
              done_q         <= 1'b1;
              misaligned_q   <= req_misaligned;
              out_of_range_q <= req_out_of_range;
            end else if (bus.we && (size_e'(bus.size) == SZ_WORD)) begin
              state_q      <= StWrite;
              mem_writeIn  <= bus.wdata;
              mem_writePin <= 1'b1;
            end else begin
              state_q     <= StRead;
              mem_readPin <= 1'b1;
            end
          end
        end
        StFault: state_q <= StIdle;
        StRead:  state_q <= we_q ? StMerge : StExtract;
        StExtract: begin
          rdata_q <= load_val;
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StMerge: begin
          mem_writeIn  <= merge_val;
          mem_writePin <= 1'b1;
          state_q      <= StWrite;
        end
        StWrite: begin
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.rdata        = rdata_q;
  assign bus.busy         = (state_q != StIdle);
  assign bus.done         = done_q;
  assign bus.misaligned   = misaligned_q;
  assign bus.out_of_range = out_of_range_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboarded bench for load_store_unit: a driver issues requests and queues the expected
// response from a byte-level memory model; a monitor checks each done pulse against the queue.
module tb_load_store_unit;
  import lsu_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    bit          mis;
    bit          oor;
    int          lat;
    int          writes;
    int          reads;
    logic [31:0] adr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] mem_adr;
  logic [31:0] mem_writeIn;
  logic [31:0] mem_readOut;
  logic        mem_writePin;
  logic        mem_readPin;

  lsu_if bus ();

  load_store_unit #(
    .DEPTH_WORDS (8),
    .IDX_W       (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .mem_adr      (mem_adr),
    .mem_writeIn  (mem_writeIn),
    .mem_readOut  (mem_readOut),
    .mem_writePin (mem_writePin),
    .mem_readPin  (mem_readPin)
  );

  always #5 clk = ~clk;

  // Data memory: registered read, synchronous write.
  logic [31:0] ram [8];
  always @(posedge clk) begin
    if (mem_writePin) ram[mem_adr[2:0]] <= mem_writeIn;
    if (mem_readPin)  mem_readOut <= ram[mem_adr[2:0]];
  end

  exp_t        exp_q[$];
  logic [31:0] model_mem [8];
  logic [31:0] last_rdata;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic issue(input bit we, input logic [1:0] size, input bit sx,
                       input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    int          guard;
    int unsigned widx, off, nb;
    logic [31:0] mask, v;
    guard = 0;
    @(negedge clk);
    while (bus.busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_wait: busy still 1 after %0d cycles, required 0", guard);
    end
    widx  = addr >> 2;
    off   = addr % 4;
    e.adr = addr >> 2;
    e.oor = (widx >= 8) || (size == 2'b11);
    e.mis = (size == 2'b01 && (addr % 2) != 0) || (size == 2'b10 && (addr % 4) != 0);
    if (e.mis || e.oor) begin
      e.lat = 1; e.writes = 0; e.reads = 0;
    end else begin
      nb   = 1 << size;
      mask = (nb == 4) ? 32'hffff_ffff : (32'd1 << (8 * nb)) - 1;
      if (we) begin
        model_mem[widx] = (model_mem[widx] & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
        e.writes = 1;
        e.reads  = (nb == 4) ? 0 : 1;
        e.lat    = (nb == 4) ? 2 : 4;
      end else begin
        v = (model_mem[widx] >> (8 * off)) & mask;
        if (sx && nb < 4 && v[8*nb-1]) v = v | ~mask;
        last_rdata = v;
        e.writes = 0; e.reads = 1; e.lat = 3;
      end
    end
    e.rdata      = last_rdata;
    bus.we       = we;
    bus.size     = size;
    bus.sign_ext = sx;
    bus.addr     = addr;
    bus.wdata    = wdata;
    bus.req      = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || bus.busy) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rdata"}, bus.rdata, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_flags"}, {30'd0, bus.misaligned, bus.out_of_range}, 32'd0);
    check({tag, "_pins"}, {30'd0, mem_writePin, mem_readPin}, 32'd0);
    check({tag, "_mem_adr"}, mem_adr, 32'd0);
    check({tag, "_mem_writeIn"}, mem_writeIn, 32'd0);
  endtask

  initial begin : monitor
    bit   pre_req, pre_busy;
    int   edges, acc_edge, wr, rd;
    exp_t e;
    edges = 0; acc_edge = 0; wr = 0; rd = 0;
    forever begin
      @(negedge clk);
      #2;
      pre_req  = bus.req;
      pre_busy = bus.busy;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        wr = 0; rd = 0;
        continue;
      end
      edges++;
      if (pre_req && !pre_busy) begin
        acc_edge = edges; wr = 0; rd = 0;
      end
      if (mem_writePin || mem_readPin) begin
        check("pin_exclusive", {31'd0, mem_writePin & mem_readPin}, 32'd0);
        if (mem_writePin) wr++;
        if (mem_readPin) rd++;
        if (exp_q.size() > 0) check("mem_adr", mem_adr, exp_q[0].adr);
      end
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: done=1 with nothing outstanding, required done=0");
        end else begin
          e = exp_q.pop_front();
          check("rdata", bus.rdata, e.rdata);
          check("misaligned", {31'd0, bus.misaligned}, {31'd0, e.mis});
          check("out_of_range", {31'd0, bus.out_of_range}, {31'd0, e.oor});
          check("latency", edges - acc_edge + 1, e.lat);
          check("write_pulses", wr, e.writes);
          check("read_pulses", rd, e.reads);
        end
      end
    end
  end

  initial begin : driver
    bit          we, sx;
    logic [1:0]  sz;
    logic [31:0] a, saved;
    int unsigned off;
    int          guard;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
    bus.addr = '0; bus.wdata = '0;
    last_rdata = '0;
    #1 rst_n = 1'b0;
    #2 check_outputs_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) issue(1'b1, SZ_WORD, 1'b0, 32'(i * 4), $urandom);

    issue(1'b1, SZ_WORD, 1'b0, 32'h0C, 32'hDEAD_BEEF);
    issue(1'b0, SZ_WORD, 1'b0, 32'h0C, 32'h0);
    issue(1'b1, SZ_WORD, 1'b0, 32'h0C, 32'h0000_80FF);
    issue(1'b0, SZ_BYTE, 1'b1, 32'h0D, 32'h0);
    issue(1'b0, SZ_BYTE, 1'b0, 32'h0D, 32'h0);
    issue(1'b0, SZ_HALF, 1'b1, 32'h0C, 32'h0);
    issue(1'b1, SZ_WORD, 1'b0, 32'h08, 32'h1122_3344);
    issue(1'b1, SZ_BYTE, 1'b0, 32'h0A, 32'hFFFF_FFAA);
    issue(1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0);
    issue(1'b1, SZ_HALF, 1'b0, 32'h0A, 32'h1234_BEEF);
    issue(1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0);
    issue(1'b0, SZ_WORD, 1'b0, 32'h02, 32'h0);
    issue(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0);
    issue(1'b0, 2'b11, 1'b0, 32'h04, 32'h0);
    issue(1'b1, SZ_HALF, 1'b0, 32'h8000_0004, 32'h0);

    // A store raised while the load is in READ must be dropped.
    issue(1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0);
    bus.we = 1'b1; bus.size = SZ_WORD; bus.addr = 32'h08; bus.wdata = 32'h0; bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    drain();
    check("word2_after_rmw", ram[2], 32'hBEEF_3344);
    check("word3_after_store", ram[3], 32'h0000_80FF);

    for (int n = 0; n < 80; n++) begin
      we  = 1'($urandom_range(0, 1));
      sx  = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      off = $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0 && sz != 2'b11) off = off & ~((32'd1 << sz) - 1);
      a = 32'($urandom_range(0, 9) * 4 + off);
      if ($urandom_range(0, 15) == 0) a = a | 32'h4000_0000;
      issue(we, sz, sx, a, $urandom);
    end
    drain();

    // Abort a sub-word store while its write pulse is pending.
    saved = model_mem[5];
    issue(1'b1, SZ_BYTE, 1'b0, 32'h15, 32'h0000_005A);
    guard = 0;
    while (!mem_writePin && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("rst_reach_write", {31'd0, mem_writePin}, 32'd1);
    rst_n = 1'b0;
    #1 check_outputs_zero("midrst");
    exp_q.delete();
    model_mem[5] = saved;
    last_rdata   = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_word_kept", ram[5], saved);
    rst_n = 1'b1;
    issue(1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0);
    issue(1'b0, SZ_BYTE, 1'b1, 32'h17, 32'h0);
    drain();

    for (int i = 0; i < 8; i++) check($sformatf("final_word%0d", i), ram[i], model_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage placed directly upstream of the word-addressed data memory in the non-pipelined MIPS datapath.
- Accepts one load/store request from the execute stage: byte (lb/lbu/sb), halfword (lh/lhu/sh) or word (lw/sw) at a byte address.
- Converts the byte address to a word index and drives the memory's clk-synchronous read/write pins.
- Performs read-modify-write for sub-word stores, extracts and extends sub-word loads, and raises busy to stall the CPU until done.

Parameters:
- DEPTH_WORDS, 8, number of 32-bit words in the data memory; word index >= DEPTH_WORDS is out of range.
- IDX_W, 3, width of the word index actually decoded (clog2 of DEPTH_WORDS).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  request strobe, sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  32  byte address.
- wdata  in  32  store data; the active lane is in the low bits.
- rdata  out  32  load result, held until the next load completes.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle completion pulse.
- misaligned  out  1  valid with done: half at addr[0]=1, or word at addr[1:0]!=0.
- out_of_range  out  1  valid with done: addr[31:2] >= DEPTH_WORDS, or size=11.
- mem_adr  out  32  word index to memory: zero-extended addr[31:2].
- mem_writeIn  out  32  write word to memory.
- mem_readOut  in  32  memory read data; registered by memory on the clk edge where mem_readPin=1.
- mem_writePin  out  1  memory write enable.
- mem_readPin  out  1  memory read enable.

Behaviour:
- Reset (async, rst_n=0): state IDLE; rdata, busy, done, misaligned, out_of_range, mem_writePin, mem_readPin, mem_adr, mem_writeIn all 0.
  - Reset mid-operation aborts immediately and drops mem_writePin combinationally-before-edge, so no partial write occurs.
  - Memory contents are not touched by reset.
- Request capture:
  - In IDLE, req=1 at an edge latches we, size, sign_ext, addr, wdata.
  - req while busy is ignored; no queueing.
- Byte lanes are little-endian: addr[1:0]=0 selects bits 7:0; half lane 0 = bits 15:0, half lane 1 = bits 31:16.
- States: IDLE, FAULT, READ, EXTRACT, MERGE, WRITE, DONE.
  - IDLE -> FAULT if the request is misaligned, out of range or size=11; otherwise IDLE -> READ for loads and sub-word stores, IDLE -> WRITE for word stores.
  - FAULT: done=1 with the relevant flags set for one cycle; no memory pin asserted; rdata unchanged; -> IDLE.
  - READ: mem_readPin=1, mem_adr valid; -> EXTRACT for loads, -> MERGE for stores.
  - EXTRACT: select the lane from mem_readOut, sign/zero-extend into rdata at the edge; -> DONE.
  - MERGE: replace the addressed lane of mem_readOut with wdata[7:0] or wdata[15:0] into the write buffer; -> WRITE.
  - WRITE: mem_writePin=1, mem_writeIn = write buffer (word store: latched wdata); -> DONE.
  - DONE: done=1, flags 0; -> IDLE. A new req can be accepted in the following IDLE cycle.
- Latency, counted in edges after the acceptance edge, with done high during the cycle after the last one:
  - word store: 2 edges.
  - load: 3 edges.
  - sub-word store: 4 edges.
  - fault: 1 edge.
- busy = (state != IDLE). mem_readPin and mem_writePin are never high together.
- mem_adr is held stable for the whole operation. Address bits above IDX_W are covered by the range check.

Decomposition:
- Package lsu_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, DEPTH_WORDS default.
- Sub-module lsu_lane_align (combinational): extract(word, addr[1:0], size, sign_ext) and merge(word, wdata, addr[1:0], size).

Test Plan:
- Word store then load: sw 0xDEADBEEF @0x0C -> mem_writePin for 1 cycle at mem_adr=3, done after 2 edges; lw @0x0C -> rdata=0xDEADBEEF, done after 3 edges.
- Byte extend: word 3 = 0x000080FF; lb @0x0D -> 0xFFFFFF80; lbu @0x0D -> 0x00000080; lh @0x0C -> 0xFFFF80FF.
- Sub-word store RMW: word 2 = 0x11223344; sb 0xAA @0x0A -> word 2 = 0x11AA3344; sh 0xBEEF @0x0A -> 0xBEEF3344; done after 4 edges, one write pulse each.
- Faults: lw @0x02 -> misaligned=1 with done one edge later, no memory pin ever high; lw @0x20 -> out_of_range=1; size=11 -> out_of_range=1.
- Busy/ignore: assert req again during READ of a load -> second request ignored, only one done pulse; back-to-back req in the IDLE after done -> accepted.
- Reset mid-RMW: drop rst_n during WRITE before the edge -> mem_writePin=0 immediately, word unchanged, all outputs 0, state IDLE after release.
